// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
// Holds the FSM state encoding, the requester count and index width, and
// the round-robin winner search used by rr_arbiter8.
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_result_t;

  // Scan last+1, last+2, ... wrapping modulo NUM_REQ; the first set bit wins.
  // The final candidate is last itself, so the previous owner only wins when
  // nobody else is requesting.
  function automatic rr_result_t next_rr(input logic [NUM_REQ-1:0] req,
                                         input logic [IDX_W-1:0]   last);
    rr_result_t       res;
    logic [IDX_W-1:0] cand;
    res = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last + IDX_W'(k);
      if (!res.found && req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter8_decoder.sv
// Enabled 3-to-8 one-hot decoder. Purely combinational; the arbiter
// registers its output so the grant lines only change on clock edges.
module rr_arbiter8_decoder
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0]   sel,
  input  logic               en,
  output logic [NUM_REQ-1:0] onehot
);

  // One output line per index, active only while enabled.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_line
      assign onehot[gi] = en && (sel == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters driving an enabled 3-to-8 decoder.
// Grants are held until the owner drops its request, and every change of
// owner passes through a one-cycle GAP with no grant active.
// Optional macro ARB_TIMEOUT_EN adds a hold counter that preempts an owner
// after MAX_HOLD consecutive grant cycles when another requester waits.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [IDX_W-1:0]   A,
  output logic               E,
  output logic [NUM_REQ-1:0] D,
  output logic               busy
);

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     a_reg, a_next;
  logic                 e_reg, e_next;
  logic [NUM_REQ-1:0]   d_reg, dec_out;
  logic                 busy_reg, busy_next;
  logic [IDX_W-1:0]     last_reg, last_next;
  logic                 timeout_hit;
  rr_result_t           win;

  assign win = next_rr(req, last_reg);

`ifdef ARB_TIMEOUT_EN
  logic [7:0]           hold_reg, hold_next;
  logic [NUM_REQ-1:0]   owner_mask;
  logic                 others_pending;

  assign owner_mask     = NUM_REQ'(1) << a_reg;
  assign others_pending = |(req & ~owner_mask);
  // Once the counter has reached the limit (including the saturated value
  // after an uncontested overrun) any newly pending requester preempts.
  assign timeout_hit    = (hold_reg >= 8'(MAX_HOLD - 1)) && others_pending;
`else
  // No hold limit: a grant ends only when the owner releases its request.
  wire unused_max_hold = ^32'(MAX_HOLD);
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic; outputs are computed here and registered below.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    e_next     = 1'b0;
    last_next  = last_reg;
`ifdef ARB_TIMEOUT_EN
    hold_next  = hold_reg;
`endif
    case (state_reg)
      ST_IDLE, ST_GAP: begin
        if (win.found) begin
          state_next = ST_GRANT;
          a_next     = win.idx;
          e_next     = 1'b1;
          last_next  = win.idx;
`ifdef ARB_TIMEOUT_EN
          hold_next  = 8'd0;
`endif
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!req[a_reg] || timeout_hit) begin
          state_next = ST_GAP;
        end else begin
          e_next = 1'b1;
`ifdef ARB_TIMEOUT_EN
          if (hold_reg < 8'(MAX_HOLD))
            hold_next = hold_reg + 8'd1;
`endif
        end
      end
      default: state_next = ST_IDLE;
    endcase
    busy_next = (state_next != ST_IDLE);
  end

  // Decoder is fed from the next-state index/enable so D lines up with A/E.
  rr_arbiter8_decoder u_decoder (
    .sel    (a_next),
    .en     (e_next),
    .onehot (dec_out)
  );

  // State and registered outputs; reset forces everything idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      e_reg     <= 1'b0;
      d_reg     <= '0;
      busy_reg  <= 1'b0;
      last_reg  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      e_reg     <= e_next;
      d_reg     <= dec_out;
      busy_reg  <= busy_next;
      last_reg  <= last_next;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter: cleared on entry to GRANT, counts grant cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_reg <= 8'd0;
    else     hold_reg <= hold_next;
  end
`endif

  assign A    = a_reg;
  assign E    = e_reg;
  assign D    = d_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Testbench for rr_arbiter8: directed stimulus pushes expected grants into a
// scoreboard queue; a monitor pops an entry on each new grant (E rising)
// and checks the owner index and the length of the preceding E=0 gap.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [2:0] A;
  logic       E;
  logic [7:0] D;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] idx;
    int         gap;   // required E=0 cycles before this grant, -1 = any
  } exp_t;

  exp_t sb[$];

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .A    (A),
    .E    (E),
    .D    (D),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: one-hot consistency every cycle, scoreboard on each new grant.
  logic       prev_e   = 1'b0;
  int         zero_run = 0;
  always @(negedge clk) begin
    logic [7:0] exp_d;
    exp_t       e;
    exp_d = E ? (8'h01 << A) : 8'h00;
    checks++;
    if (D !== exp_d || (E === 1'b1 && busy !== 1'b1)) begin
      errors++;
      $display("FAIL onehot: E=%0b A=%0d D=%h busy=%0b required D=%h", E, A, D, busy, exp_d);
    end
    if (E === 1'b1 && prev_e == 1'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected: A=%0d required no grant", A);
      end else begin
        e = sb.pop_front();
        $display("grant: A=%0d expected=%0d gap=%0d", A, e.idx, zero_run);
        if (A !== e.idx) begin
          errors++;
          $display("FAIL grant_idx: A=%0d required %0d", A, e.idx);
        end
        if (e.gap >= 0) begin
          checks++;
          if (zero_run != e.gap) begin
            errors++;
            $display("FAIL grant_gap: gap=%0d required %0d", zero_run, e.gap);
          end
        end
      end
    end
    if (E === 1'b1) zero_run = 0;
    else            zero_run++;
    prev_e = (E === 1'b1);
  end

  task automatic push(input logic [2:0] idx, input int gap);
    exp_t e;
    e.idx = idx;
    e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req_v);
    end else begin
      $display("check %s: %0h", name, act);
    end
  endtask

  // Advance at least one cycle, then until E equals val (bounded).
  task automatic wait_e(input logic val, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (E !== val && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (E !== val) begin
      errors++;
      $display("FAIL %s: E=%0b after timeout, required %0b", name, E, val);
    end
  endtask

  // Count consecutive E=1 cycles starting at the current negedge.
  task automatic count_hold(input int cap, output int n);
    n = 0;
    while (E === 1'b1 && n < cap) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = 8'h00;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("reset_A", 32'(A), 32'd0);
    check("reset_E", 32'(E), 32'd0);
    check("reset_D", 32'(D), 32'h00);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // No requests: stays idle.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (E !== 1'b0 || D !== 8'h00 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle: E=%0b D=%h busy=%0b required 0/00/0", E, D, busy);
      end
    end

    // Single request: one-cycle latency.
    push(3'd0, -1);
    req = 8'h01;
    @(negedge clk);
    check("lat_E", 32'(E), 32'd1);
    check("lat_A", 32'(A), 32'd0);
    check("lat_D", 32'(D), 32'h01);
    check("lat_busy", 32'(busy), 32'd1);
    req = 8'h00;
    @(negedge clk);
    check("gap_E", 32'(E), 32'd0);
    check("gap_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("back_idle_busy", 32'(busy), 32'd0);

    // All requesting, each owner blips its bit: 0..7,0 with 1-cycle gaps.
    do_reset();
    push(3'd0, -1);
    for (int i = 1; i <= 8; i++) push(3'(i % 8), 1);
    req = 8'hFF;
    for (int i = 0; i <= 8; i++) begin
      wait_e(1'b1, "rr_wait");
      req = 8'hFF & ~(8'h01 << (i % 8));
      @(negedge clk);
      req = (i == 8) ? 8'h00 : 8'hFF;
    end

    // Owner 3 with 5 pending, then 3 again after 5 releases.
    do_reset();
    push(3'd3, -1);
    req = 8'h08;
    wait_e(1'b1, "own3_wait");
    req = 8'h28;
    repeat (2) @(negedge clk);
    push(3'd5, 1);
    req = 8'h20;
    wait_e(1'b1, "own5_wait");
    req = 8'h28;
    repeat (2) @(negedge clk);
    push(3'd3, 1);
    req = 8'h08;
    wait_e(1'b1, "own3b_wait");
    req = 8'h00;
    repeat (3) @(negedge clk);

    // Hold behaviour with two constant requesters.
    do_reset();
`ifdef ARB_TIMEOUT_EN
    push(3'd0, -1);
    push(3'd1, 1);
    push(3'd0, 1);
    req = 8'h03;
    wait_e(1'b1, "to_wait0");
    count_hold(40, n);
    check("to_hold0", 32'(n), 32'd4);
    wait_e(1'b1, "to_wait1");
    count_hold(40, n);
    check("to_hold1", 32'(n), 32'd4);
    wait_e(1'b1, "to_wait2");
    req = 8'h00;
    repeat (3) @(negedge clk);
    push(3'd0, -1);
    req = 8'h01;
    wait_e(1'b1, "to_solo_wait");
    count_hold(40, n);
    check("to_solo_hold", 32'(n), 32'd40);
    req = 8'h00;
`else
    push(3'd0, -1);
    push(3'd1, 1);
    req = 8'h03;
    wait_e(1'b1, "hold_wait");
    count_hold(40, n);
    check("hold_forever", 32'(n), 32'd40);
    req = 8'h02;
    wait_e(1'b1, "hold_next_wait");
    req = 8'h00;
`endif
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a grant to requester 6.
    do_reset();
    push(3'd6, -1);
    req = 8'h40;
    wait_e(1'b1, "own6_wait");
    #2 rst = 1'b1;
    #1;
    check("arst_E", 32'(E), 32'd0);
    check("arst_D", 32'(D), 32'h00);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_A", 32'(A), 32'd0);
    req = 8'h41;
    push(3'd0, -1);
    @(negedge clk);
    rst = 1'b0;
    wait_e(1'b1, "after_rst_wait");
    req = 8'h00;

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
